// File: rtl/final_tcp_hw_timer_pkg.sv
// Register map, control bits, command/state encodings and bus helpers for the TCP timer controller.
// The SNAP states exist only when TCP_TMR_SNAP_EN is defined.
package final_tcp_hw_timer_pkg;

   localparam logic [2:0] ADDR_STATUS = 3'd0;
   localparam logic [2:0] ADDR_CTRL   = 3'd1;
   localparam logic [2:0] ADDR_PL     = 3'd2;
   localparam logic [2:0] ADDR_PH     = 3'd3;
   localparam logic [2:0] ADDR_SL     = 3'd4;
   localparam logic [2:0] ADDR_SH     = 3'd5;

   localparam int CTL_ITO   = 0;
   localparam int CTL_CONT  = 1;
   localparam int CTL_START = 2;
   localparam int CTL_STOP  = 3;

   typedef enum logic [1:0] {
      OP_NOP   = 2'd0,
      OP_START = 2'd1,
      OP_STOP  = 2'd2,
      OP_SNAP  = 2'd3
   } cmd_op_t;

   typedef enum logic [3:0] {
      S_IDLE, S_CLR_ST, S_WR_PL, S_WR_PH, S_WR_CTL, S_WR_STOP
`ifdef TCP_TMR_SNAP_EN
      , S_WR_SN, S_RD_L, S_RD_H, S_RD_CAP
`endif
   } state_t;

   typedef struct packed {
      logic        cs;
      logic        write_n;
      logic [2:0]  addr;
      logic [15:0] wdata;
   } avm_req_t;

   localparam avm_req_t BUS_IDLE = '{cs: 1'b0, write_n: 1'b1, addr: 3'd0, wdata: 16'd0};

   function automatic avm_req_t bus_wr(input logic [2:0] a, input logic [15:0] d);
      return '{cs: 1'b1, write_n: 1'b0, addr: a, wdata: d};
   endfunction

   function automatic avm_req_t bus_rd(input logic [2:0] a);
      return '{cs: 1'b1, write_n: 1'b1, addr: a, wdata: 16'd0};
   endfunction

   function automatic logic [15:0] ctl_word(input logic stop, input logic start,
                                            input logic cont, input logic ito);
      logic [15:0] w;
      w            = '0;
      w[CTL_STOP]  = stop;
      w[CTL_START] = start;
      w[CTL_CONT]  = cont;
      w[CTL_ITO]   = ito;
      return w;
   endfunction

endpackage

// File: rtl/final_tcp_hw_timer_ctrl.sv
// Avalon-MM master sequencing START/STOP/SNAP commands and irq service onto the TCP interval timer.
// Define TCP_TMR_SNAP_EN to enable the SNAP read-back sequence; otherwise SNAP behaves as NOP.
module final_tcp_hw_timer_ctrl
   import final_tcp_hw_timer_pkg::*;
#(
   parameter bit CONT_MODE = 1'b0,
   parameter bit IRQ_EN    = 1'b1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [1:0]  cmd_op,
   input  logic [31:0] cmd_period,
   input  logic        irq,
   output logic [2:0]  avm_address,
   output logic        avm_chipselect,
   output logic        avm_write_n,
   output logic [15:0] avm_writedata,
   input  logic [15:0] avm_readdata,
   output logic        timeout_pulse,
   output logic        snap_valid,
   output logic [31:0] snap_value,
   output logic        busy
);

   state_t      state;
   avm_req_t    bus_q;
   logic [1:0]  op_q;
   logic [31:0] period_q;
   logic        pend_q;
   logic        accept;
   logic [1:0]  op_sel;
   logic [31:0] period_sel;

   assign accept     = cmd_valid && cmd_ready;
   assign op_sel     = pend_q ? op_q : cmd_op;
   assign period_sel = pend_q ? period_q : cmd_period;

   assign avm_chipselect = bus_q.cs;
   assign avm_write_n    = bus_q.write_n;
   assign avm_address    = bus_q.addr;
   assign avm_writedata  = bus_q.wdata;

`ifdef TCP_TMR_SNAP_EN
   logic [15:0] snap_lo_q;
   logic        snap_valid_q;
   logic [31:0] snap_value_q;
   assign snap_valid = snap_valid_q;
   assign snap_value = snap_value_q;
`else
   logic unused_rdata;
   assign unused_rdata = ^avm_readdata;
   assign snap_valid   = 1'b0;
   assign snap_value   = '0;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state         <= S_IDLE;
         bus_q         <= BUS_IDLE;
         op_q          <= '0;
         period_q      <= '0;
         pend_q        <= 1'b0;
         cmd_ready     <= 1'b0;
         timeout_pulse <= 1'b0;
         busy          <= 1'b0;
`ifdef TCP_TMR_SNAP_EN
         snap_lo_q     <= '0;
         snap_valid_q  <= 1'b0;
         snap_value_q  <= '0;
`endif
      end else begin
         bus_q         <= BUS_IDLE;
         timeout_pulse <= 1'b0;
         cmd_ready     <= 1'b0;
         busy          <= 1'b1;
`ifdef TCP_TMR_SNAP_EN
         snap_valid_q  <= 1'b0;
`endif
         case (state)
            S_IDLE: begin
               if (accept) begin
                  op_q     <= cmd_op;
                  period_q <= cmd_period;
               end
               // A command handshaken in the same cycle irq rises is parked until the clear is done.
               if (irq) begin
                  state         <= S_CLR_ST;
                  bus_q         <= bus_wr(ADDR_STATUS, 16'd0);
                  timeout_pulse <= 1'b1;
                  if (accept) pend_q <= 1'b1;
               end else if (pend_q || accept) begin
                  pend_q <= 1'b0;
                  case (cmd_op_t'(op_sel))
                     OP_START: begin
                        state <= S_WR_PL;
                        bus_q <= bus_wr(ADDR_PL, period_sel[15:0]);
                     end
                     OP_STOP: begin
                        state <= S_WR_STOP;
                        bus_q <= bus_wr(ADDR_CTRL, ctl_word(1'b1, 1'b0, CONT_MODE, IRQ_EN));
                     end
`ifdef TCP_TMR_SNAP_EN
                     OP_SNAP: begin
                        state <= S_WR_SN;
                        bus_q <= bus_wr(ADDR_SL, 16'd0);
                     end
`endif
                     default: begin
                        busy      <= 1'b0;
                        cmd_ready <= 1'b1;
                     end
                  endcase
               end else begin
                  busy      <= 1'b0;
                  cmd_ready <= 1'b1;
               end
            end
            S_CLR_ST: begin
               state     <= S_IDLE;
               busy      <= 1'b0;
               cmd_ready <= !irq && !pend_q;
            end
            S_WR_PL: begin
               state <= S_WR_PH;
               bus_q <= bus_wr(ADDR_PH, period_q[31:16]);
            end
            S_WR_PH: begin
               state <= S_WR_CTL;
               bus_q <= bus_wr(ADDR_CTRL, ctl_word(1'b0, 1'b1, CONT_MODE, IRQ_EN));
            end
`ifdef TCP_TMR_SNAP_EN
            S_WR_SN: begin
               state <= S_RD_L;
               bus_q <= bus_rd(ADDR_SL);
            end
            S_RD_L: begin
               state <= S_RD_H;
               bus_q <= bus_rd(ADDR_SH);
            end
            S_RD_H: begin
               state     <= S_RD_CAP;
               snap_lo_q <= avm_readdata;
            end
            S_RD_CAP: begin
               state        <= S_IDLE;
               snap_value_q <= {avm_readdata, snap_lo_q};
               snap_valid_q <= 1'b1;
               busy         <= 1'b0;
               cmd_ready    <= !irq;
            end
`endif
            default: begin
               state     <= S_IDLE;
               busy      <= 1'b0;
               cmd_ready <= !irq;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_final_tcp_hw_timer_ctrl.sv
// Directed + randomized bench for the TCP timer controller against a small timer slave model
// and a transaction-level expectation queue.
module tb_final_tcp_hw_timer_ctrl;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_op;
   logic [31:0] cmd_period;
   logic        irq;
   logic [2:0]  avm_address;
   logic        avm_chipselect;
   logic        avm_write_n;
   logic [15:0] avm_writedata;
   logic [15:0] avm_readdata;
   logic        timeout_pulse;
   logic        snap_valid;
   logic [31:0] snap_value;
   logic        busy;

   final_tcp_hw_timer_ctrl dut (
      .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_period(cmd_period), .irq(irq),
      .avm_address(avm_address), .avm_chipselect(avm_chipselect), .avm_write_n(avm_write_n),
      .avm_writedata(avm_writedata), .avm_readdata(avm_readdata),
      .timeout_pulse(timeout_pulse), .snap_valid(snap_valid), .snap_value(snap_value), .busy(busy)
   );

   always #5 clk = ~clk;

   // Timer slave: irq cleared by any status write, snapshot latched by a write to addr4.
   logic        irq_raise;
   logic [31:0] tmr_count;
   logic [31:0] tmr_snap;
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         irq          <= 1'b0;
         avm_readdata <= '0;
         tmr_snap     <= '0;
      end else begin
         if (avm_chipselect && !avm_write_n && avm_address == 3'd0) irq <= 1'b0;
         else if (irq_raise) irq <= 1'b1;
         if (avm_chipselect && !avm_write_n && avm_address == 3'd4) tmr_snap <= tmr_count;
         if (avm_chipselect && avm_write_n)
            avm_readdata <= (avm_address == 3'd4) ? tmr_snap[15:0] :
                            (avm_address == 3'd5) ? tmr_snap[31:16] : 16'd0;
      end
   end

   typedef struct {
      int          cyc;
      logic [2:0]  a;
      logic        wn;
      logic [15:0] d;
      bit          chk_d;
   } txn_t;

   txn_t        obs_q[$];
   txn_t        exp_q[$];
   int          cyc = 0;
   int          n_to = 0;
   int          n_snap = 0;
   logic [31:0] snap_seen = '0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (avm_chipselect)
         obs_q.push_back('{cyc: cyc, a: avm_address, wn: avm_write_n, d: avm_writedata, chk_d: 1'b1});
      if (timeout_pulse) n_to <= n_to + 1;
      if (snap_valid) begin
         n_snap    <= n_snap + 1;
         snap_seen <= snap_value;
      end
   end

   int n_cmp = 0;
   int n_err = 0;
   int rd_ptr = 0;

   task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
      n_cmp++;
      assert (o === e) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, o, e);
      end
   endtask

   function automatic void exp_wr(input logic [2:0] a, input logic [15:0] d, input bit cd);
      exp_q.push_back('{cyc: 0, a: a, wn: 1'b0, d: d, chk_d: cd});
   endfunction

   function automatic void exp_rd(input logic [2:0] a);
      exp_q.push_back('{cyc: 0, a: a, wn: 1'b1, d: 16'd0, chk_d: 1'b0});
   endfunction

   // Expected bus traffic derived from the command semantics.
   function automatic void exp_start(input logic [31:0] p);
      exp_wr(3'd2, p[15:0], 1'b1);
      exp_wr(3'd3, p[31:16], 1'b1);
      exp_wr(3'd1, 16'h0005, 1'b1);
   endfunction

   task automatic check_bus(input string tag);
      int n_obs;
      n_obs = obs_q.size() - rd_ptr;
      chk($sformatf("%s_len", tag), 32'(n_obs), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < n_obs; i++) begin
         chk($sformatf("%s_addr%0d", tag, i), 32'(obs_q[rd_ptr+i].a), 32'(exp_q[i].a));
         chk($sformatf("%s_wn%0d", tag, i), 32'(obs_q[rd_ptr+i].wn), 32'(exp_q[i].wn));
         if (exp_q[i].chk_d)
            chk($sformatf("%s_data%0d", tag, i), 32'(obs_q[rd_ptr+i].d), 32'(exp_q[i].d));
      end
      rd_ptr = obs_q.size();
      exp_q.delete();
   endtask

   task automatic issue(input logic [1:0] op, input logic [31:0] p);
      int k = 0;
      @(negedge clk);
      while (!cmd_ready && k < 50) begin
         @(negedge clk);
         k++;
      end
      chk("cmd_ready_wait", 32'(cmd_ready), 32'd1);
      cmd_valid  = 1'b1;
      cmd_op     = op;
      cmd_period = p;
      @(posedge clk);
      #1;
      cmd_valid  = 1'b0;
      cmd_op     = 2'($urandom);
      cmd_period = $urandom;
   endtask

   task automatic raise_irq();
      irq_raise = 1'b1;
      @(posedge clk);
      #1;
      irq_raise = 1'b0;
   endtask

   initial begin
      int          n0;
      int          nb;
      logic [31:0] p;
      logic [31:0] plist [5];

      reset_n    = 1'b0;
      cmd_valid  = 1'b0;
      cmd_op     = '0;
      cmd_period = '0;
      irq_raise  = 1'b0;
      tmr_count  = '0;
      repeat (3) @(negedge clk);
      chk("rst_cs", 32'(avm_chipselect), 32'd0);
      chk("rst_wn", 32'(avm_write_n), 32'd1);
      chk("rst_addr", 32'(avm_address), 32'd0);
      chk("rst_wd", 32'(avm_writedata), 32'd0);
      chk("rst_ready", 32'(cmd_ready), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_to", 32'(timeout_pulse), 32'd0);
      chk("rst_snapv", 32'(snap_valid), 32'd0);
      chk("rst_snap", snap_value, 32'd0);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("post_rst_ready", 32'(cmd_ready), 32'd1);

      // 1: START with the reference period; busy spans the three writes.
      exp_start(32'h0001_86A0);
      issue(2'd1, 32'h0001_86A0);
      nb = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (busy) nb++;
         else break;
      end
      chk("t1_busy_cycles", 32'(nb), 32'd3);
      repeat (3) @(negedge clk);
      check_bus("t1");
      chk("t1_idle_wn", 32'(avm_write_n), 32'd1);

      // Random and boundary periods, including 0 (written unclamped) and all-ones.
      plist[0] = 32'h0000_0000;
      plist[1] = 32'hFFFF_FFFF;
      for (int i = 2; i < 5; i++) plist[i] = $urandom;
      for (int i = 0; i < 5; i++) begin
         exp_start(plist[i]);
         issue(2'd1, plist[i]);
         repeat (6) @(negedge clk);
         check_bus($sformatf("start%0d", i));
      end

      // NOP: accepted, no bus traffic.
      issue(2'd0, $urandom);
      repeat (4) @(negedge clk);
      check_bus("nop");
      chk("nop_busy", 32'(busy), 32'd0);

      // 2: irq service produces one status write and one timeout pulse.
      n0 = n_to;
      @(negedge clk);
      raise_irq();
      repeat (6) @(negedge clk);
      exp_wr(3'd0, 16'd0, 1'b1);
      check_bus("t2");
      chk("t2_pulses", 32'(n_to - n0), 32'd1);
      chk("t2_irq_low", 32'(irq), 32'd0);

      // 3: command and irq together: status clear first, then the START.
      n0 = n_to;
      p  = $urandom;
      @(negedge clk);
      raise_irq();
      @(negedge clk);
      chk("t3_irq_high", 32'(irq), 32'd1);
      cmd_valid  = 1'b1;
      cmd_op     = 2'd1;
      cmd_period = p;
      @(posedge clk);
      #1;
      cmd_valid  = 1'b0;
      cmd_period = $urandom;
      chk("t3_ready_low", 32'(cmd_ready), 32'd0);
      repeat (10) @(negedge clk);
      exp_wr(3'd0, 16'd0, 1'b1);
      exp_start(p);
      check_bus("t3");
      chk("t3_pulses", 32'(n_to - n0), 32'd1);

      // 4: SNAP, reference counter then a random one.
      for (int i = 0; i < 2; i++) begin
         tmr_count = (i == 0) ? 32'h0002_0003 : $urandom;
         n0 = n_snap;
         issue(2'd3, $urandom);
         repeat (8) @(negedge clk);
`ifdef TCP_TMR_SNAP_EN
         exp_wr(3'd4, 16'd0, 1'b0);
         exp_rd(3'd4);
         exp_rd(3'd5);
         check_bus($sformatf("snap%0d", i));
         chk($sformatf("snap%0d_pulses", i), 32'(n_snap - n0), 32'd1);
         chk($sformatf("snap%0d_value", i), snap_seen, tmr_count);
`else
         check_bus($sformatf("snap%0d", i));
         chk($sformatf("snap%0d_pulses", i), 32'(n_snap - n0), 32'd0);
         chk($sformatf("snap%0d_value", i), snap_value, 32'd0);
`endif
      end

      // 5: STOP, then START with irq rising during the high-period write.
      exp_wr(3'd1, 16'h0009, 1'b1);
      issue(2'd2, $urandom);
      repeat (4) @(negedge clk);
      check_bus("t5_stop");
      n0 = n_to;
      p  = $urandom;
      exp_start(p);
      exp_wr(3'd0, 16'd0, 1'b1);
      issue(2'd1, p);
      @(negedge clk);
      raise_irq();
      repeat (8) @(negedge clk);
      if (obs_q.size() >= rd_ptr + 4)
         chk("t5_clr_gap_ok",
             32'((obs_q[rd_ptr+3].cyc - obs_q[rd_ptr+2].cyc) inside {[1:2]}), 32'd1);
      check_bus("t5_irq");
      chk("t5_pulses", 32'(n_to - n0), 32'd1);

      // 6: reset in the middle of a START sequence.
      issue(2'd1, $urandom);
      @(posedge clk);
      #2 reset_n = 1'b0;
      #1;
      chk("t6_cs", 32'(avm_chipselect), 32'd0);
      chk("t6_wn", 32'(avm_write_n), 32'd1);
      chk("t6_addr", 32'(avm_address), 32'd0);
      chk("t6_wd", 32'(avm_writedata), 32'd0);
      chk("t6_busy", 32'(busy), 32'd0);
      chk("t6_ready", 32'(cmd_ready), 32'd0);
      @(negedge clk);
      rd_ptr = obs_q.size();
      reset_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("t6_ready_after", 32'(cmd_ready), 32'd1);
      chk("t6_busy_after", 32'(busy), 32'd0);
      check_bus("t6_quiet");
      exp_wr(3'd1, 16'h0009, 1'b1);
      issue(2'd2, $urandom);
      repeat (4) @(negedge clk);
      check_bus("t6_stop");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
